// File: rtl/stream_arbiter_pkg.sv
// Shared FSM encoding and index-width helpers for the stream arbiter.
package stream_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Index width that stays legal (>= 1 bit) even for a single channel.
    function automatic int idx_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/stream_arbiter_rr_select.sv
// Circular priority picker: first set request bit strictly after ptr_i, wrapping; the ptr_i channel itself is checked last.
module rr_select
    import stream_arbiter_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int IW    = idx_w(WIDTH)
) (
    input  logic [WIDTH-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    output logic [IW-1:0]    idx_o,
    output logic             found_o
);

    int          cand;
    logic [IW-1:0] cidx;

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        cand    = 0;
        cidx    = '0;
        for (int k = 1; k <= WIDTH; k++) begin
            cand = (int'(ptr_i) + k) % WIDTH;
            cidx = IW'(cand);
            if (!found_o && req_i[cidx]) begin
                found_o = 1'b1;
                idx_o   = cidx;
            end
        end
    end

endmodule

// File: rtl/stream_arbiter.sv
// Round-robin merge of WIDTH source FIFOs into one stream; 1-cycle registered output,
// pops only when READY_IN is high; one dead cycle on every ownership switch.
module stream_arbiter
    import stream_arbiter_pkg::*;
#(
    parameter  int WIDTH     = 6,
    parameter  int DSIZE     = 32,
    parameter  int MAX_BURST = 16,
    localparam int IW        = idx_w(WIDTH)
) (
    input  logic                   BUS_CLK,
    input  logic                   BUS_RST,
    input  logic [WIDTH-1:0]       WRITE_REQ,
    input  logic [WIDTH-1:0]       HOLD_REQ,
    input  logic [WIDTH*DSIZE-1:0] DATA_IN,
    output logic [WIDTH-1:0]       READ_GRANT,
    input  logic                   READY_IN,
    output logic                   WRITE_OUT,
    output logic [DSIZE-1:0]       DATA_OUT,
    output logic [IW-1:0]          OWNER,
    output logic                   OWNER_VALID
);

    localparam int CW = clog2(MAX_BURST + 1);

    state_t           state_q;
    logic [IW-1:0]    owner_q;
    logic [IW-1:0]    last_q;
    logic [CW-1:0]    cnt_q;
    logic             wout_q;
    logic [DSIZE-1:0] dout_q;

    logic             own_req;
    logic             own_hold;
    logic             cnt_full;
    logic             rel;
    logic             grant;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    pick_idx;
    logic             pick_found;
    logic [DSIZE-1:0] sel_dat;

    // While owning, searching after the owner is exactly the release-time search.
    assign ptr = (state_q == OWN) ? owner_q : last_q;

    rr_select #(
        .WIDTH (WIDTH),
        .IW    (IW)
    ) u_rr_select (
        .req_i   (WRITE_REQ),
        .ptr_i   (ptr),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    always_comb begin
        own_req  = WRITE_REQ[owner_q];
        own_hold = HOLD_REQ[owner_q];
        cnt_full = (cnt_q == CW'(MAX_BURST));
        rel      = (state_q == OWN) && !own_hold && (!own_req || cnt_full);
        // The release cycle never pops: that is the dead cycle of a switch.
        grant    = (state_q == OWN) && own_req && READY_IN && !rel;

        READ_GRANT = '0;
        if (grant) READ_GRANT[owner_q] = 1'b1;

        sel_dat = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (owner_q == IW'(i)) sel_dat = DATA_IN[i*DSIZE +: DSIZE];
        end
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IW'(WIDTH - 1);
            cnt_q   <= '0;
            wout_q  <= 1'b0;
            dout_q  <= '0;
        end else begin
            wout_q <= grant;
            if (grant) dout_q <= sel_dat;

            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        state_q <= OWN;
                        owner_q <= pick_idx;
                        cnt_q   <= '0;
                    end
                end
                OWN: begin
                    if (rel) begin
                        last_q <= owner_q;
                        cnt_q  <= '0;
                        if (pick_found) owner_q <= pick_idx;
                        else            state_q <= IDLE;
                    end else if (grant && !cnt_full) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign WRITE_OUT   = wout_q;
    assign DATA_OUT    = dout_q;
    assign OWNER       = owner_q;
    assign OWNER_VALID = (state_q == OWN);

endmodule

// File: tb/tb_stream_arbiter.sv
// Randomised and directed bench for stream_arbiter against a queue-based model of the sources and owner.
module tb_stream_arbiter;

    localparam int W  = 6;
    localparam int DS = 32;
    localparam int MB = 16;

    logic            BUS_CLK = 1'b0;
    logic            BUS_RST;
    logic [W-1:0]    WRITE_REQ;
    logic [W-1:0]    HOLD_REQ;
    logic [W*DS-1:0] DATA_IN;
    logic [W-1:0]    READ_GRANT;
    logic            READY_IN;
    logic            WRITE_OUT;
    logic [DS-1:0]   DATA_OUT;
    logic [2:0]      OWNER;
    logic            OWNER_VALID;

    stream_arbiter #(.WIDTH(W), .DSIZE(DS), .MAX_BURST(MB)) dut (
        .BUS_CLK     (BUS_CLK),
        .BUS_RST     (BUS_RST),
        .WRITE_REQ   (WRITE_REQ),
        .HOLD_REQ    (HOLD_REQ),
        .DATA_IN     (DATA_IN),
        .READ_GRANT  (READ_GRANT),
        .READY_IN    (READY_IN),
        .WRITE_OUT   (WRITE_OUT),
        .DATA_OUT    (DATA_OUT),
        .OWNER       (OWNER),
        .OWNER_VALID (OWNER_VALID)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    int n_chk = 0;
    int n_pass = 0;

    // Source FIFOs as circular arrays; words are {channel, per-channel sequence}.
    logic [DS-1:0] mem [W][256];
    int hd [W];
    int tl [W];
    int seq [W];

    logic [W-1:0] hold_v;
    logic [W-1:0] mask_v;
    logic         ready_v;

    // Model: current owner (-1 when idle), words granted in this tenure, last served channel.
    int            m_own;
    int            m_cnt;
    int            m_last;
    logic          exp_wout;
    logic [DS-1:0] exp_dout;

    int glog [0:4095];
    int cyc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push(input int ch, input int n);
        for (int k = 0; k < n; k++) begin
            mem[ch][tl[ch] % 256] = {8'(ch), 24'(seq[ch])};
            seq[ch]++;
            tl[ch]++;
        end
    endtask

    function automatic int pick(input logic [W-1:0] req, input int after);
        for (int k = 1; k <= W; k++) begin
            if (req[(after + k) % W]) return (after + k) % W;
        end
        return -1;
    endfunction

    function automatic int count_g(input int ch, input int from, input int to);
        int n;
        n = 0;
        for (int c = from; c <= to; c++) if (glog[c] == ch) n++;
        return n;
    endfunction

    function automatic int first_gcyc(input int ch);
        for (int c = 1; c < cyc; c++) if (glog[c] == ch) return c;
        return -1;
    endfunction

    task automatic step();
        logic [W-1:0] req;
        int eg;
        int o;
        logic rel;
        for (int i = 0; i < W; i++) begin
            req[i] = (tl[i] != hd[i]) && mask_v[i];
            DATA_IN[i*DS +: DS] = (tl[i] != hd[i]) ? mem[i][hd[i] % 256] : '0;
        end
        WRITE_REQ = req;
        HOLD_REQ  = hold_v;
        READY_IN  = ready_v;
        #1;
        eg  = -1;
        rel = 1'b0;
        if (m_own >= 0) begin
            o   = m_own;
            rel = !hold_v[o] && (!req[o] || m_cnt == MB);
            if (!rel && req[o] && ready_v) eg = o;
        end
        chk("read_grant", 64'(READ_GRANT), (eg >= 0) ? (64'd1 << eg) : 64'd0);
        chk("write_out", 64'(WRITE_OUT), 64'(exp_wout));
        chk("data_out", 64'(DATA_OUT), 64'(exp_dout));
        chk("owner_valid", 64'(OWNER_VALID), 64'(m_own >= 0));
        if (m_own >= 0) chk("owner", 64'(OWNER), 64'(m_own));
        if (cyc < 4096) glog[cyc] = eg;

        exp_wout = (eg >= 0);
        if (eg >= 0) begin
            exp_dout = mem[eg][hd[eg] % 256];
            hd[eg]++;
            if (m_cnt < MB) m_cnt++;
        end
        if (m_own < 0) begin
            o = pick(req, m_last);
            if (o >= 0) begin
                m_own = o;
                m_cnt = 0;
            end
        end else if (rel) begin
            m_last = m_own;
            m_cnt  = 0;
            m_own  = pick(req, m_last);
        end
        @(posedge BUS_CLK);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        BUS_RST   = 1'b1;
        WRITE_REQ = '0;
        HOLD_REQ  = '0;
        READY_IN  = 1'b0;
        DATA_IN   = '0;
        for (int i = 0; i < W; i++) begin
            hd[i]  = 0;
            tl[i]  = 0;
            seq[i] = 0;
        end
        hold_v   = '0;
        mask_v   = '1;
        ready_v  = 1'b1;
        m_own    = -1;
        m_cnt    = 0;
        m_last   = W - 1;
        exp_wout = 1'b0;
        exp_dout = '0;
        repeat (2) @(posedge BUS_CLK);
        #1;
        BUS_RST = 1'b0;
        cyc     = 1;
    endtask

    initial begin
        int run_ch [8];
        int run_len [8];
        int run_gap [8];
        int nr;
        int gapc;
        int g;

        // Reset state and single-channel stream.
        do_reset();
        #1;
        chk("rst_write_out", 64'(WRITE_OUT), 64'd0);
        chk("rst_data_out", 64'(DATA_OUT), 64'd0);
        chk("rst_owner_valid", 64'(OWNER_VALID), 64'd0);
        chk("rst_owner", 64'(OWNER), 64'd0);
        chk("rst_read_grant", 64'(READ_GRANT), 64'd0);
        push(0, 3);
        repeat (6) step();
        chk("ch0_first_grant_cycle", 64'(first_gcyc(0)), 64'd2);
        chk("ch0_last_word", 64'(DATA_OUT), 64'h0000_0002);

        // Three channels: bursts of MAX_BURST with one dead cycle between.
        do_reset();
        push(0, 40);
        push(2, 40);
        push(5, 40);
        repeat (72) step();
        nr   = 0;
        gapc = 0;
        for (int c = 1; c < cyc; c++) begin
            g = glog[c];
            if (g >= 0) begin
                if (nr > 0 && nr <= 8 && g == run_ch[nr-1] && gapc == 0) begin
                    run_len[nr-1]++;
                end else begin
                    if (nr < 8) begin
                        run_ch[nr]  = g;
                        run_len[nr] = 1;
                        run_gap[nr] = gapc;
                    end
                    nr++;
                end
                gapc = 0;
            end else begin
                gapc++;
            end
        end
        chk("burst_runs", 64'(nr >= 4), 64'd1);
        for (int r = 0; r < 4; r++) begin
            chk("burst_len", 64'(run_len[r]), 64'd16);
            if (r > 0) chk("burst_gap", 64'(run_gap[r]), 64'd1);
        end
        chk("burst_ch0", 64'(run_ch[0]), 64'd0);
        chk("burst_ch1", 64'(run_ch[1]), 64'd2);
        chk("burst_ch2", 64'(run_ch[2]), 64'd5);
        chk("burst_ch3", 64'(run_ch[3]), 64'd0);

        // Hold keeps ch0 through gaps and an empty source while ch3 waits.
        do_reset();
        push(0, 6);
        push(3, 5);
        hold_v = 6'b000001;
        repeat (3) step();
        mask_v = 6'b111110;
        repeat (3) step();
        mask_v = '1;
        repeat (8) step();
        chk("hold_ch3_blocked", 64'(count_g(3, 1, cyc - 1)), 64'd0);
        chk("hold_ch0_words", 64'(count_g(0, 1, cyc - 1)), 64'd6);
        hold_v = '0;
        repeat (8) step();
        chk("hold_ch3_first", 64'(first_gcyc(3)), 64'd16);
        chk("hold_ch3_words", 64'(count_g(3, 1, cyc - 1)), 64'd5);

        // READY_IN toggling during a burst.
        do_reset();
        push(1, 20);
        repeat (40) begin
            ready_v = (cyc % 2 == 0);
            step();
        end
        chk("toggle_first_burst", 64'(count_g(1, 1, 33)), 64'd16);
        chk("toggle_total", 64'(count_g(1, 1, 40)), 64'd20);

        // Reset in the middle of a burst.
        do_reset();
        push(0, 30);
        push(3, 5);
        repeat (8) step();
        #2;
        BUS_RST = 1'b1;
        #1;
        chk("midrst_write_out", 64'(WRITE_OUT), 64'd0);
        chk("midrst_owner_valid", 64'(OWNER_VALID), 64'd0);
        do_reset();
        push(3, 5);
        push(0, 5);
        repeat (5) step();
        chk("midrst_first_ch", 64'(glog[2]), 64'd0);

        // Random traffic against the model.
        do_reset();
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(2, 0) == 0) begin
                int ch;
                ch = $urandom_range(W - 1, 0);
                if (tl[ch] - hd[ch] < 8) push(ch, 1 + $urandom_range(2, 0));
            end
            for (int i = 0; i < W; i++) hold_v[i] = ($urandom_range(9, 0) == 0);
            ready_v = ($urandom_range(3, 0) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
